// File: rtl/ama_riscv_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ama_riscv_hazard_ctrl_pkg
// Shared types and constants for the hazard controller and its scoreboard.
//   fwd_sel_t   : forwarding source for an EX operand (none / MEM stage / WB stage)
//   sb_entry_t  : one shadow-scoreboard slot {vld, rd, load, mult}
//   src_hit()   : "does this live ID source read the register this slot writes?"
// -----------------------------------------------------------------------------
package ama_riscv_hazard_ctrl_pkg;

  localparam int MULT_LAT_MAX = 7;
  localparam int MULT_CNT_W   = 3;   // holds MULT_LAT_MAX-1
  localparam int SB_ENTRY_W   = 8;

  localparam logic [4:0] RF_X0_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       load;
    logic       mult;
  } sb_entry_t;

  // x0 and sources the instruction does not read never create a dependency.
  function automatic logic src_hit(input logic src_en, input logic [4:0] src,
                                   input sb_entry_t e);
    return src_en && (src != RF_X0_ZERO) && e.vld && (e.rd == src);
  endfunction

endpackage

// File: rtl/ama_riscv_hazard_sb.sv
// -----------------------------------------------------------------------------
// ama_riscv_hazard_sb
// Two-entry shadow scoreboard (EX, MEM) mirroring the writers in flight, plus
// the multiplier occupancy counter and the destination of the last mult.
//   clk, rst_n     : clock, asynchronous active-low reset
//   issue          : ID instruction advances into EX this cycle
//   freeze         : whole pipe holds; nothing here changes
//   id_entry       : sb_entry_t of the ID instruction (vld = rd_we)
//   id_mult        : ID instruction uses the multiplier
//   ex_entry       : slot for the instruction now in EX
//   mem_entry      : slot for the instruction now in MEM
//   mult_cnt       : cycles left until the last mult result is forwardable
//   mult_rd        : destination of the last issued mult (x0 if it writes nothing)
// -----------------------------------------------------------------------------
module ama_riscv_hazard_sb
  import ama_riscv_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 2   // 1..MULT_LAT_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  freeze,
  input  logic [SB_ENTRY_W-1:0] id_entry,
  input  logic                  id_mult,
  output logic [SB_ENTRY_W-1:0] ex_entry,
  output logic [SB_ENTRY_W-1:0] mem_entry,
  output logic [MULT_CNT_W-1:0] mult_cnt,
  output logic [4:0]            mult_rd
);

  localparam logic [MULT_CNT_W-1:0] CNT_INIT = MULT_CNT_W'(MULT_LAT - 1);
  localparam logic [MULT_CNT_W-1:0] CNT_ONE  = MULT_CNT_W'(1);

  sb_entry_t             id_e;
  sb_entry_t             ex_q, ex_d;
  sb_entry_t             mem_q, mem_d;
  logic [MULT_CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]            mult_rd_q, mult_rd_d;

  assign id_e = sb_entry_t'(id_entry);

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    cnt_d     = cnt_q;
    mult_rd_d = mult_rd_q;
    if (!freeze) begin
      mem_d = ex_q;
      // Anything not issuing (stall, flush, empty ID) becomes a bubble in EX;
      // non-writers are also tracked as empty since nothing can depend on them.
      ex_d  = '0;
      if (issue && id_e.vld) begin
        ex_d = id_e;
      end
      if (issue && id_mult) begin
        cnt_d     = CNT_INIT;
        mult_rd_d = id_e.vld ? id_e.rd : RF_X0_ZERO;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      cnt_q     <= '0;
      mult_rd_q <= RF_X0_ZERO;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      cnt_q     <= cnt_d;
      mult_rd_q <= mult_rd_d;
    end
  end

  assign ex_entry  = ex_q;
  assign mem_entry = mem_q;
  assign mult_cnt  = cnt_q;
  assign mult_rd   = mult_rd_q;

endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// ama_riscv_hazard_ctrl
// Pipeline sequencer between ID and EX/MEM/WB: detects load-use and multiplier
// hazards for the ID instruction, generates stall/bubble/flush/freeze, gates the
// frontend PC write and registers the EX operand forwarding selects.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid, id_rs1, id_rs2,  ID instruction, its sources and destination
//   id_rd, id_has_reg          {rd,rs1,rs2} usage flags from the decoder
//   id_rd_we, id_load, id_mult writer / load / multiplier (incl. SIMD dot)
//   dec_pc_we                  decoder's frontend PC write request
//   ex_redirect                taken branch/jump resolved in EX
//   dmem_busy, imem_busy       memory wait states
//   pc_we, stall_id, bubble_ex, flush_id, freeze   pipeline controls
//   fwd_rs1_sel, fwd_rs2_sel   fwd_sel_t for the instruction in EX
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit event counters
//   cnt_load_use, cnt_mult_stall, cnt_freeze, cnt_flush.
// Priority: freeze > ex_redirect > stall_id > imem_busy.
// -----------------------------------------------------------------------------
module ama_riscv_hazard_ctrl
  import ama_riscv_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 2   // 1..MULT_LAT_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_has_reg,
  input  logic        id_rd_we,
  input  logic        id_load,
  input  logic        id_mult,
  input  logic        dec_pc_we,
  input  logic        ex_redirect,
  input  logic        dmem_busy,
  input  logic        imem_busy,
  output logic        pc_we,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        freeze,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] cnt_load_use,
  output logic [31:0] cnt_mult_stall,
  output logic [31:0] cnt_freeze,
  output logic [31:0] cnt_flush
`endif
);

  localparam logic [MULT_CNT_W-1:0] CNT_ONE = MULT_CNT_W'(1);

  sb_entry_t             id_e;
  logic [SB_ENTRY_W-1:0] ex_raw, mem_raw;
  sb_entry_t             ex_e, mem_e;
  logic [MULT_CNT_W-1:0] mult_cnt;
  logic [4:0]            mult_rd;
  logic                  issue;

  assign id_e = '{vld: id_rd_we, rd: id_rd, load: id_load, mult: id_mult};

  ama_riscv_hazard_sb #(
    .MULT_LAT (MULT_LAT)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .freeze    (freeze),
    .id_entry  (id_e),
    .id_mult   (id_mult),
    .ex_entry  (ex_raw),
    .mem_entry (mem_raw),
    .mult_cnt  (mult_cnt),
    .mult_rd   (mult_rd)
  );

  assign ex_e  = sb_entry_t'(ex_raw);
  assign mem_e = sb_entry_t'(mem_raw);

  // ---------------------------------------------------------------------------
  // Per-source hazard and forwarding (index 0 = rs1, 1 = rs2)
  // ---------------------------------------------------------------------------
  logic [1:0]  src_en;
  logic [9:0]  src_addr;
  logic [1:0]  load_use_src;
  logic [1:0]  mult_use_src;
  logic [3:0]  fwd_d;

  assign src_en   = {id_has_reg[0], id_has_reg[1]};
  assign src_addr = {id_rs2, id_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [4:0] addr;
      logic       hit_ex;
      logic       hit_mem;

      assign addr    = src_addr[gi*5 +: 5];
      assign hit_ex  = src_hit(src_en[gi], addr, ex_e);
      assign hit_mem = src_hit(src_en[gi], addr, mem_e);

      assign load_use_src[gi] = hit_ex && ex_e.load;
      assign mult_use_src[gi] = src_en[gi] && (addr != RF_X0_ZERO) &&
                                (addr == mult_rd) && (mult_cnt != '0);

      // The EX producer is one stage younger than MEM, so it wins.
      assign fwd_d[gi*2 +: 2] = hit_ex  ? FWD_MEM :
                                hit_mem ? FWD_WB  : FWD_NONE;
    end
  endgenerate

  logic load_use;
  logic mult_use;
  logic mult_struct;

  assign load_use    = |load_use_src;
  assign mult_use    = |mult_use_src;
  assign mult_struct = id_mult && (mult_cnt > CNT_ONE);

  // A redirect kills the ID instruction, so any hazard it had is moot.
  assign stall_id  = id_valid && (load_use || mult_use || mult_struct) && !ex_redirect;
  assign bubble_ex = stall_id;
  assign flush_id  = ex_redirect;
  assign freeze    = dmem_busy;
  assign pc_we     = !freeze && (ex_redirect || (dec_pc_we && !stall_id && !imem_busy));
  assign issue     = id_valid && !stall_id && !freeze && !flush_id;

  // ---------------------------------------------------------------------------
  // Forwarding selects follow the instruction into EX; held otherwise.
  // ---------------------------------------------------------------------------
  logic [1:0] fwd_rs1_q, fwd_rs2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_rs1_q <= FWD_NONE;
      fwd_rs2_q <= FWD_NONE;
    end else if (issue) begin
      fwd_rs1_q <= fwd_d[1:0];
      fwd_rs2_q <= fwd_d[3:2];
    end
  end

  assign fwd_rs1_sel = fwd_rs1_q;
  assign fwd_rs2_sel = fwd_rs2_q;

  // Slot fields carried for a complete entry but not needed by these rules.
  logic unused_fields;
  assign unused_fields = ^{ex_e.mult, mem_e.load, mem_e.mult, id_has_reg[2]};

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Event counters: one count per cycle of cause; frozen cycles only count as
  // freeze. Saturate instead of wrapping.
  // ---------------------------------------------------------------------------
  logic [3:0]       perf_inc;
  logic [3:0][31:0] perf_cnt;

  assign perf_inc[0] = !freeze && id_valid && load_use && !ex_redirect;
  assign perf_inc[1] = !freeze && id_valid && (mult_use || mult_struct) && !ex_redirect;
  assign perf_inc[2] = freeze;
  assign perf_inc[3] = !freeze && ex_redirect;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_perf
      logic [31:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (perf_inc[gi] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
      assign perf_cnt[gi] = cnt_q;
    end
  endgenerate

  assign cnt_load_use   = perf_cnt[0];
  assign cnt_mult_stall = perf_cnt[1];
  assign cnt_freeze     = perf_cnt[2];
  assign cnt_flush      = perf_cnt[3];
`endif

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_hazard_ctrl
// Randomized stimulus against a pipeline-timeline reference: every cycle that
// is not frozen is one "tick"; an instruction issued at tick T is in EX during
// tick T+1 and in MEM during T+2, and a mult issued at tick M is still busy at
// tick t while M+MULT_LAT-t > 0.
// -----------------------------------------------------------------------------
module tb_ama_riscv_hazard_ctrl;
  import ama_riscv_hazard_ctrl_pkg::*;

  localparam int MULT_LAT = 3;
  localparam int N_CYC    = 2500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_has_reg = '0;
  logic       id_rd_we = 1'b0, id_load = 1'b0, id_mult = 1'b0;
  logic       dec_pc_we = 1'b0, ex_redirect = 1'b0;
  logic       dmem_busy = 1'b0, imem_busy = 1'b0;
  logic       pc_we, stall_id, bubble_ex, flush_id, freeze;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_load_use, cnt_mult_stall, cnt_freeze, cnt_flush;
`endif

  always #5 clk = ~clk;

  ama_riscv_hazard_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_has_reg  (id_has_reg),
    .id_rd_we    (id_rd_we),
    .id_load     (id_load),
    .id_mult     (id_mult),
    .dec_pc_we   (dec_pc_we),
    .ex_redirect (ex_redirect),
    .dmem_busy   (dmem_busy),
    .imem_busy   (imem_busy),
    .pc_we       (pc_we),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_id    (flush_id),
    .freeze      (freeze),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cnt_load_use   (cnt_load_use),
    .cnt_mult_stall (cnt_mult_stall),
    .cnt_freeze     (cnt_freeze),
    .cnt_flush      (cnt_flush)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         t;
    logic [4:0] rd;
    bit         load;
  } wr_t;

  wr_t        wr_q[$];      // issued register writers, oldest first
  int         tick;
  bit         mult_seen;
  int         mult_t;
  logic [4:0] mult_rd_m;
  logic [1:0] exp_fwd1, exp_fwd2;
  int         m_lu, m_ms, m_fz, m_fl;

  task automatic model_reset();
    wr_q.delete();
    tick      = 0;
    mult_seen = 1'b0;
    mult_t    = 0;
    mult_rd_m = '0;
    exp_fwd1  = FWD_NONE;
    exp_fwd2  = FWD_NONE;
    m_lu = 0; m_ms = 0; m_fz = 0; m_fl = 0;
  endtask

  // Writer that issued 'age' ticks ago, if any.
  function automatic bit writer_at(input int age, output logic [4:0] rd, output bit load);
    rd   = '0;
    load = 1'b0;
    foreach (wr_q[k]) begin
      if (wr_q[k].t == tick - age) begin
        rd   = wr_q[k].rd;
        load = wr_q[k].load;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int mult_left();
    int r;
    if (!mult_seen) return 0;
    r = mult_t + MULT_LAT - tick;
    return (r > 0) ? r : 0;
  endfunction

  function automatic logic [1:0] fwd_of(input bit live, input logic [4:0] src,
                                        input bit ex_f, input logic [4:0] ex_rd,
                                        input bit mem_f, input logic [4:0] mem_rd);
    if (live && ex_f && ex_rd == src)   return FWD_MEM;
    if (live && mem_f && mem_rd == src) return FWD_WB;
    return FWD_NONE;
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic check_outputs(input bit e_stall, input bit e_flush, input bit e_frz, input bit e_pc);
    chk_eq("stall_id",  32'(stall_id),    32'(e_stall));
    chk_eq("bubble_ex", 32'(bubble_ex),   32'(e_stall));
    chk_eq("flush_id",  32'(flush_id),    32'(e_flush));
    chk_eq("freeze",    32'(freeze),      32'(e_frz));
    chk_eq("pc_we",     32'(pc_we),       32'(e_pc));
    chk_eq("fwd_rs1",   32'(fwd_rs1_sel), 32'(exp_fwd1));
    chk_eq("fwd_rs2",   32'(fwd_rs2_sel), 32'(exp_fwd2));
`ifdef HAZARD_PERF_CNT_EN
    chk_eq("cnt_load_use",   cnt_load_use,   32'(m_lu));
    chk_eq("cnt_mult_stall", cnt_mult_stall, 32'(m_ms));
    chk_eq("cnt_freeze",     cnt_freeze,     32'(m_fz));
    chk_eq("cnt_flush",      cnt_flush,      32'(m_fl));
`endif
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_has_reg = '0;
    id_rd_we = 1'b0; id_load = 1'b0; id_mult = 1'b0; dec_pc_we = 1'b0;
    ex_redirect = 1'b0; dmem_busy = 1'b0; imem_busy = 1'b0;
  endtask

  task automatic drive_random();
    int r;
    id_valid    = ($urandom_range(0, 99) < 85);
    id_rs1      = pick_reg();
    id_rs2      = pick_reg();
    id_rd       = pick_reg();
    id_has_reg  = 3'($urandom_range(0, 7) | (($urandom_range(0, 1) == 1) ? 7 : 0));
    id_rd_we    = id_has_reg[2] && (id_rd != 5'd0) && ($urandom_range(0, 7) != 0);
    r           = $urandom_range(0, 9);
    id_load     = (r < 3);
    id_mult     = (r == 3 || r == 4);
    dec_pc_we   = ($urandom_range(0, 9) != 0);
    ex_redirect = ($urandom_range(0, 99) < 8);
    dmem_busy   = ($urandom_range(0, 99) < 10);
    imem_busy   = ($urandom_range(0, 99) < 15);
  endtask

  task automatic do_reset_check(input string tag);
    drive_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset (%s) applied", tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit         live1, live2, ex_f, mem_f, ex_ld, mem_ld;
    logic [4:0] ex_rd, mem_rd;
    bit         lu, mu, ms, e_stall, e_pc, e_issue;
    int         left;

    model_reset();
    @(negedge clk);
    do_reset_check("power-on");

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (cyc == 900 || cyc == 1800) begin
        do_reset_check("mid-run");
        @(negedge clk);
      end
      drive_random();
      #1;

      live1 = id_has_reg[1] && (id_rs1 != 5'd0);
      live2 = id_has_reg[0] && (id_rs2 != 5'd0);
      ex_f  = writer_at(1, ex_rd, ex_ld);
      mem_f = writer_at(2, mem_rd, mem_ld);
      left  = mult_left();

      lu = ex_f && ex_ld && ((live1 && id_rs1 == ex_rd) || (live2 && id_rs2 == ex_rd));
      mu = (left != 0) && ((live1 && id_rs1 == mult_rd_m) || (live2 && id_rs2 == mult_rd_m));
      ms = id_mult && (left > 1);

      e_stall = id_valid && (lu || mu || ms) && !ex_redirect;
      e_pc    = !dmem_busy && (ex_redirect || (dec_pc_we && !e_stall && !imem_busy));
      check_outputs(e_stall, ex_redirect, dmem_busy, e_pc);

      // advance the model across the coming clock edge
      if (!dmem_busy) begin
        if (id_valid && lu && !ex_redirect)          m_lu++;
        if (id_valid && (mu || ms) && !ex_redirect)  m_ms++;
        if (ex_redirect)                             m_fl++;
      end else begin
        m_fz++;
      end

      e_issue = id_valid && !e_stall && !dmem_busy && !ex_redirect;
      if (e_issue) begin
        exp_fwd1 = fwd_of(live1, id_rs1, ex_f, ex_rd, mem_f, mem_rd);
        exp_fwd2 = fwd_of(live2, id_rs2, ex_f, ex_rd, mem_f, mem_rd);
        if (id_rd_we) wr_q.push_back('{t: tick, rd: id_rd, load: id_load});
        if (id_mult) begin
          mult_seen = 1'b1;
          mult_t    = tick;
          mult_rd_m = id_rd_we ? id_rd : 5'd0;
        end
        $display("[TB] cyc %0d issue rd=x%0d we=%0b rs1=x%0d rs2=x%0d ld=%0b mul=%0b fwd=%0d/%0d",
                 cyc, id_rd, id_rd_we, id_rs1, id_rs2, id_load, id_mult, exp_fwd1, exp_fwd2);
      end
      if (!dmem_busy) tick++;
      while (wr_q.size() > 0 && wr_q[0].t < tick - 2) void'(wr_q.pop_front());
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
